mat_vec_mul_driver_dim_4: RTL and testbench

Initiator side of the 4x4 matrix-vector multiplier handshake. The block holds a transform matrix and accepts 3-component vertices from upstream. It extends each vertex to homogeneous form (w = 1.0 fixed-point), issues one job at a time to `mat_vec_mul_dim_4`, collects the 4-component result and presents it downstream with valid/ready. It sits between the vertex fetch stage and the clip/perspective stage of the render pipeline.

---
 rtl/mat_vec_mul_driver_dim_4_pkg.sv | 16 +
 rtl/mat_vec_mul_driver_dim_4_if.sv | 21 ++
 rtl/mat_vec_mul_driver_dim_4_watchdog.sv | 28 ++
 rtl/mat_vec_mul_driver_dim_4.sv | 150 +++++++++++++++
 tb/tb_mat_vec_mul_driver_dim_4.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mat_vec_mul_driver_dim_4_pkg.sv
// Shared render-pipeline types for the matrix-vector multiplier driver.
// Holds the driver FSM encoding and the fixed-point 1.0 used for homogeneous w.
package render_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_OUTPUT = 2'd3
    } mvm_drv_state_t;

    localparam int FRAC_BITS_DEF = 16;

    localparam logic [63:0] FIXED_ONE = 64'd1 << FRAC_BITS_DEF;

endpackage

// File: rtl/mat_vec_mul_driver_dim_4_if.sv
// Operand/result bus between the driver (master) and mat_vec_mul_dim_4 (slave).
interface mat_vec_mul_driver_dim_4_if #(
    parameter int DATAWIDTH = 32
);
    logic [3:0][3:0][DATAWIDTH-1:0] m_A;
    logic [3:0][DATAWIDTH-1:0]      m_x;
    logic                           m_dv;
    logic                           m_ready;
    logic                           m_result_dv;
    logic [3:0][DATAWIDTH-1:0]      m_y;

    modport master (
        output m_A, m_x, m_dv,
        input  m_ready, m_result_dv, m_y
    );

    modport slave (
        input  m_A, m_x, m_dv,
        output m_ready, m_result_dv, m_y
    );
endinterface

// File: rtl/mat_vec_mul_driver_dim_4_watchdog.sv
// WAIT-state timeout counter for the multiplier driver.
// Compiled only when MVM_DRV_TIMEOUT_EN is defined.
`ifdef MVM_DRV_TIMEOUT_EN
module mvm_watchdog #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Fires during the LIMIT-th enabled cycle after a clear.
    assign o_expired = i_enable && (r_cnt == CW'(LIMIT - 1));
endmodule
`endif

// File: rtl/mat_vec_mul_driver_dim_4.sv
// Initiator for mat_vec_mul_dim_4: homogenises vertices, issues one job at a time,
// returns results downstream. Optional watchdog under macro MVM_DRV_TIMEOUT_EN.
module mat_vec_mul_driver_dim_4
    import render_pkg::*;
#(
    parameter int DATAWIDTH      = 32,
    parameter int FRAC_BITS      = FRAC_BITS_DEF,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_mat_load,
    input  logic [3:0][3:0][DATAWIDTH-1:0] i_mat,
    output logic                           o_mat_ready,
    input  logic                           i_valid,
    input  logic [2:0][DATAWIDTH-1:0]      i_vtx,
    output logic                           o_in_ready,
    mat_vec_mul_driver_dim_4_if.master     mvm,
    output logic                           o_valid,
    output logic [3:0][DATAWIDTH-1:0]      o_y,
    input  logic                           i_ready,
    output logic [15:0]                    o_count,
    output logic                           o_error
);
    localparam logic [DATAWIDTH-1:0] W_ONE = (FRAC_BITS == FRAC_BITS_DEF) ?
        DATAWIDTH'(FIXED_ONE) : DATAWIDTH'(64'd1 << FRAC_BITS);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    mvm_drv_state_t                 r_state;
    mvm_drv_state_t                 w_next;
    logic [3:0][3:0][DATAWIDTH-1:0] r_mat;
    logic [3:0][DATAWIDTH-1:0]      r_vec;
    logic [3:0][DATAWIDTH-1:0]      r_y;
    logic [15:0]                    r_count;
    logic                           w_mat_we;
    logic                           w_accept;
    logic                           w_issue;
    logic                           w_result;
    logic                           w_done;
    logic                           w_timeout;

    assign w_mat_we = (r_state == ST_IDLE) && i_mat_load;
    assign w_accept = (r_state == ST_IDLE) && i_valid;
    assign w_issue  = (r_state == ST_ISSUE) && mvm.m_ready;
    assign w_result = (r_state == ST_WAIT) && mvm.m_result_dv;
    assign w_done   = (r_state == ST_OUTPUT) && i_ready;

`ifdef MVM_DRV_TIMEOUT_EN
    logic w_expired;
    logic r_error;

    mvm_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_issue),
        .i_enable  (r_state == ST_WAIT),
        .o_expired (w_expired)
    );

    // A result arriving in the expiry cycle still wins over the timeout.
    assign w_timeout = w_expired && !mvm.m_result_dv;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_error <= 1'b0;
        end else if (w_timeout) begin
            r_error <= 1'b1;
        end
    end

    assign o_error = r_error;
`else
    assign w_timeout = 1'b0;
    assign o_error   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (i_valid) w_next = ST_ISSUE;
            ST_ISSUE:  if (mvm.m_ready) w_next = ST_WAIT;
            ST_WAIT: begin
                if (mvm.m_result_dv) begin
                    w_next = ST_OUTPUT;
                end else if (w_timeout) begin
                    w_next = ST_IDLE;
                end
            end
            ST_OUTPUT: if (i_ready) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_in_ready  = 1'b0;
        o_mat_ready = 1'b0;
        o_valid     = 1'b0;
        mvm.m_dv    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_in_ready  = 1'b1;
                o_mat_ready = 1'b1;
            end
            ST_ISSUE:  mvm.m_dv = mvm.m_ready;
            ST_OUTPUT: o_valid  = 1'b1;
            default: ;
        endcase
    end

    // Operand and result registers only change in IDLE/WAIT, so m_A/m_x stay stable in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mat   <= '0;
            r_vec   <= '0;
            r_y     <= '0;
            r_count <= '0;
        end else begin
            if (w_mat_we) begin
                r_mat <= i_mat;
            end
            if (w_accept) begin
                r_vec <= {W_ONE, i_vtx[2], i_vtx[1], i_vtx[0]};
            end
            if (w_result) begin
                r_y <= mvm.m_y;
            end
            if (w_done) begin
                r_count <= r_count + 16'd1;
            end
        end
    end

    assign mvm.m_A = r_mat;
    assign mvm.m_x = r_vec;
    assign o_y     = r_y;
    assign o_count = r_count;
endmodule

// File: tb/tb_mat_vec_mul_driver_dim_4.sv
// Directed self-checking bench for mat_vec_mul_driver_dim_4 with a behavioural
// latency-6 multiplier; the timeout steps run when MVM_DRV_TIMEOUT_EN is defined.
module tb_mat_vec_mul_driver_dim_4;
    localparam int DW = 32;
    localparam int L  = 6;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    i_mat_load;
    logic [3:0][3:0][DW-1:0] i_mat;
    logic                    o_mat_ready;
    logic                    i_valid;
    logic [2:0][DW-1:0]      i_vtx;
    logic                    o_in_ready;
    logic                    o_valid;
    logic [3:0][DW-1:0]      o_y;
    logic                    i_ready;
    logic [15:0]             o_count;
    logic                    o_error;

    logic                    tb_m_ready;
    logic                    stray_dv = 1'b0;
    logic                    mdl_drop = 1'b0;
    logic                    mdl_busy = 1'b0;
    int                      mdl_cnt  = 0;
    logic [3:0][DW-1:0]      mdl_res  = '0;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mat_vec_mul_driver_dim_4_if #(.DATAWIDTH(DW)) mvm_if ();

    mat_vec_mul_driver_dim_4 #(
        .DATAWIDTH      (DW),
        .FRAC_BITS      (16),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_mat_load  (i_mat_load),
        .i_mat       (i_mat),
        .o_mat_ready (o_mat_ready),
        .i_valid     (i_valid),
        .i_vtx       (i_vtx),
        .o_in_ready  (o_in_ready),
        .mvm         (mvm_if),
        .o_valid     (o_valid),
        .o_y         (o_y),
        .i_ready     (i_ready),
        .o_count     (o_count),
        .o_error     (o_error)
    );

    function automatic logic [3:0][DW-1:0] mvm_ref(input logic [3:0][3:0][DW-1:0] a,
                                                   input logic [3:0][DW-1:0] x);
        logic [3:0][DW-1:0] y;
        for (int r = 0; r < 4; r++) begin
            y[r] = '0;
            for (int c = 0; c < 4; c++) y[r] = y[r] + a[r][c] * x[c];
        end
        return y;
    endfunction

    // Behavioural multiplier: latches a job on m_dv, strobes the result L cycles later.
    always @(posedge clk) begin
        if (mdl_busy) begin
            if (mdl_cnt == 0) mdl_busy <= 1'b0;
            else mdl_cnt <= mdl_cnt - 1;
        end else if (mvm_if.m_dv) begin
            mdl_busy <= 1'b1;
            mdl_cnt  <= L - 1;
            mdl_res  <= mvm_ref(mvm_if.m_A, mvm_if.m_x);
        end
    end

    assign mvm_if.m_ready     = tb_m_ready;
    assign mvm_if.m_result_dv = (mdl_busy && (mdl_cnt == 0) && !mdl_drop) || stray_dv;
    assign mvm_if.m_y         = stray_dv ? {4{32'hDEAD_BEEF}} : mdl_res;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (o_valid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk(tag, o_valid, 1'b1);
    endtask

    task automatic run_vertex(input logic [2:0][DW-1:0] v, input string tag);
        i_vtx   = v;
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        wait_valid(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed no finish, required finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [3:0][3:0][DW-1:0] ident;
        logic [3:0][3:0][DW-1:0] dbl;
        logic [3:0][3:0][DW-1:0] junk;
        int cyc;
        int n_dv;
        int bad;

        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                ident[r][c] = (r == c) ? 32'd1 : 32'd0;
                dbl[r][c]   = (r == c) ? 32'd2 : 32'd0;
                junk[r][c]  = 32'd7;
            end
        end

        rst        = 1'b1;
        i_mat_load = 1'b0;
        i_mat      = '0;
        i_valid    = 1'b0;
        i_vtx      = '0;
        i_ready    = 1'b1;
        tb_m_ready = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready", o_in_ready, 1'b1);
        chk("rst_mat_ready", o_mat_ready, 1'b1);
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_m_dv", mvm_if.m_dv, 1'b0);
        chk("rst_count", o_count, 16'd0);
        chk("rst_error", o_error, 1'b0);
        chk("rst_o_y", o_y, 128'd0);
        chk("rst_m_x", mvm_if.m_x, 128'd0);
        chk("rst_m_A", mvm_if.m_A, 512'd0);

        // Identity load and basic issue/return
        i_mat      = ident;
        i_mat_load = 1'b1;
        step();
        i_mat_load = 1'b0;
        chk("load_ident", mvm_if.m_A, ident);

        i_vtx   = {32'h40000, 32'h30000, 32'h20000};
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        chk("basic_m_dv", mvm_if.m_dv, 1'b1);
        chk("basic_m_x", mvm_if.m_x, {32'h10000, 32'h40000, 32'h30000, 32'h20000});
        chk("basic_busy_in_ready", o_in_ready, 1'b0);
        cyc  = 1;
        n_dv = 1;
        while (o_valid !== 1'b1 && cyc < 40) begin
            step();
            cyc++;
            if (mvm_if.m_dv === 1'b1) n_dv++;
        end
        chk("basic_valid_cycle", cyc, 8);
        chk("basic_dv_pulses", n_dv, 1);
        chk("basic_o_y", o_y, {32'h10000, 32'h40000, 32'h30000, 32'h20000});
        step();
        chk("basic_count", o_count, 16'd1);
        chk("basic_valid_drop", o_valid, 1'b0);
        chk("basic_back_idle", o_in_ready, 1'b1);

        // Multiplier backpressure
        tb_m_ready = 1'b0;
        i_vtx      = {32'd3, 32'd2, 32'd1};
        i_valid    = 1'b1;
        step();
        i_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (mvm_if.m_dv !== 1'b0 || o_in_ready !== 1'b0) bad++;
            step();
        end
        chk("issue_hold_bad", bad, 0);
        chk("issue_hold_m_x", mvm_if.m_x, {32'h10000, 32'd3, 32'd2, 32'd1});
        tb_m_ready = 1'b1;
        #1;
        chk("issue_release_dv", mvm_if.m_dv, 1'b1);
        step();
        chk("issue_dv_single", mvm_if.m_dv, 1'b0);

        // Downstream backpressure
        i_ready = 1'b0;
        wait_valid("bp_valid");
        chk("bp_o_y", o_y, {32'h10000, 32'd3, 32'd2, 32'd1});
        i_vtx   = {32'd7, 32'd6, 32'd5};
        i_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (o_valid !== 1'b1 || o_in_ready !== 1'b0 ||
                o_y !== {32'h10000, 32'd3, 32'd2, 32'd1}) bad++;
        end
        chk("bp_hold_bad", bad, 0);
        chk("bp_count_held", o_count, 16'd1);
        i_ready = 1'b1;
        step();
        chk("bp_release_idle", o_in_ready, 1'b1);
        chk("bp_release_count", o_count, 16'd2);
        step();
        i_valid = 1'b0;
        chk("bp_next_dv", mvm_if.m_dv, 1'b1);
        chk("bp_next_m_x", mvm_if.m_x, {32'h10000, 32'd7, 32'd6, 32'd5});

        // Matrix load during WAIT is refused
        step();
        i_mat      = junk;
        i_mat_load = 1'b1;
        #1;
        chk("wait_mat_ready", o_mat_ready, 1'b0);
        step();
        i_mat_load = 1'b0;
        chk("wait_load_ignored", mvm_if.m_A, ident);
        wait_valid("wait_load_valid");
        chk("wait_load_o_y", o_y, {32'h10000, 32'd7, 32'd6, 32'd5});
        step();
        chk("wait_load_count", o_count, 16'd3);

        // Matrix load together with a vertex uses the new matrix
        i_mat      = dbl;
        i_mat_load = 1'b1;
        i_vtx      = {32'd3, 32'd2, 32'd1};
        i_valid    = 1'b1;
        step();
        i_mat_load = 1'b0;
        i_valid    = 1'b0;
        chk("same_cycle_m_A", mvm_if.m_A, dbl);
        wait_valid("same_cycle_valid");
        chk("same_cycle_o_y", o_y, {32'h20000, 32'd6, 32'd4, 32'd2});
        step();
        chk("same_cycle_count", o_count, 16'd4);

        // Stray result in IDLE is dropped
        stray_dv = 1'b1;
        step();
        stray_dv = 1'b0;
        chk("stray_valid", o_valid, 1'b0);
        chk("stray_idle", o_in_ready, 1'b1);
        chk("stray_o_y", o_y, {32'h20000, 32'd6, 32'd4, 32'd2});

        // Reset during WAIT, late result ignored
        i_vtx   = {32'd1, 32'd1, 32'd1};
        i_valid = 1'b1;
        step();
        i_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_valid", o_valid, 1'b0);
        chk("midrst_m_dv", mvm_if.m_dv, 1'b0);
        chk("midrst_count", o_count, 16'd0);
        chk("midrst_in_ready", o_in_ready, 1'b1);
        chk("midrst_m_A", mvm_if.m_A, 512'd0);
        chk("midrst_m_x", mvm_if.m_x, 128'd0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (o_valid !== 1'b0) bad++;
        end
        chk("midrst_late_ignored", bad, 0);
        chk("midrst_o_y", o_y, 128'd0);

        // Count wrap from 0xFFFE
        i_mat      = ident;
        i_mat_load = 1'b1;
        step();
        i_mat_load = 1'b0;
        force dut.r_count = 16'hFFFE;
        #1;
        release dut.r_count;
        chk("wrap_preset", o_count, 16'hFFFE);
        run_vertex({32'd9, 32'd8, 32'd7}, "wrap_v1_valid");
        chk("wrap_v1_o_y", o_y, {32'h10000, 32'd9, 32'd8, 32'd7});
        step();
        chk("wrap_ffff", o_count, 16'hFFFF);
        run_vertex({32'd4, 32'd5, 32'd6}, "wrap_v2_valid");
        step();
        chk("wrap_zero", o_count, 16'h0000);

`ifdef MVM_DRV_TIMEOUT_EN
        // Watchdog timeout
        mdl_drop = 1'b1;
        i_vtx    = {32'd2, 32'd2, 32'd2};
        i_valid  = 1'b1;
        step();
        i_valid = 1'b0;
        cyc = 0;
        while (o_in_ready !== 1'b1 && cyc < 200) begin
            step();
            cyc++;
        end
        chk("to_cycles", cyc, 65);
        chk("to_error", o_error, 1'b1);
        chk("to_count", o_count, 16'h0000);
        chk("to_no_valid", o_valid, 1'b0);
        mdl_drop = 1'b0;
        for (int i = 0; i < 10; i++) step();
        run_vertex({32'd3, 32'd2, 32'd1}, "to_next_valid");
        chk("to_next_o_y", o_y, {32'h10000, 32'd3, 32'd2, 32'd1});
        step();
        chk("to_next_count", o_count, 16'h0001);
        chk("to_error_sticky", o_error, 1'b1);
`else
        chk("no_to_error", o_error, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
